// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared state encoding and round-robin index helper for the FIFO drain scheduler
package fifo_sched_pkg;
  typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/fifo_rr_drain_sched_arb.sv
// rr_arbiter: combinational rotate-priority encoder, first requester after last_grant wins
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_valid
);
  int idx;
  always_comb begin
    gnt_idx = '0;
    gnt_valid = 1'b0;
    idx = int'(last_grant);
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr_next(idx, NUM_CH);
      if (req[idx[CH_W-1:0]] && !gnt_valid) begin
        gnt_idx = idx[CH_W-1:0];
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_drain_sched.sv
// fifo_rr_drain_sched: round-robin burst scheduler draining NUM_CH FIFO read ports into one tagged stream
module fifo_rr_drain_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN = 4,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(BURST_LEN + 1)
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [NUM_CH-1:0]            ch_empty_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata_i,
  input  logic [NUM_CH-1:0]            ch_mask_i,
  output logic [NUM_CH-1:0]            ch_rd_en_o,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [CH_W-1:0]              m_ch_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic                         busy_o
);
  state_t state, state_n;
  logic [CH_W-1:0] grant, arb_idx;
  logic arb_valid;
  logic [CNT_W-1:0] burst_cnt;
  logic [NUM_CH-1:0] eligible;
  logic out_free, pop, last_pop;
  logic [DATA_WIDTH-1:0] grant_data;
  assign eligible = ch_mask_i & ~ch_empty_i;
  assign out_free = ~m_valid_o | m_ready_i;
  assign pop = (state == BURST) & out_free & eligible[grant];
  assign last_pop = pop & (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign grant_data = ch_rdata_i[grant*DATA_WIDTH +: DATA_WIDTH];
  assign ch_rd_en_o = pop ? NUM_CH'(1) << grant : '0;
  assign busy_o = state != IDLE;
  // grant doubles as last_grant: it only changes in ARB, so it always holds the latest winner
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req(eligible),
    .last_grant(grant),
    .gnt_idx(arb_idx),
    .gnt_valid(arb_valid)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |eligible ? ARB : IDLE;
      ARB:     state_n = arb_valid ? BURST : IDLE;
      BURST:   state_n = (last_pop | (out_free & ~eligible[grant])) ? ARB : BURST;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      grant <= CH_W'(NUM_CH - 1);
      burst_cnt <= '0;
      m_valid_o <= 1'b0;
      m_data_o <= '0;
      m_ch_o <= '0;
    end else begin
      state <= state_n;
      if (state == ARB && arb_valid) begin
        grant <= arb_idx;
        burst_cnt <= '0;
      end
      if (pop) begin
        m_data_o <= grant_data;
        m_ch_o <= grant;
        m_valid_o <= 1'b1;
        burst_cnt <= burst_cnt + 1'b1;
      end else if (m_ready_i) m_valid_o <= 1'b0;
    end
  end
endmodule
